input_module_16to304: RTL and testbench

- Receiver-side deserializer for the OFDM chain. It is the counterpart of the transmit 304-to-16 serializer.
- Accepts the 16-bit sample stream word by word and reassembles each 304-bit cyclic-prefixed symbol.
- Strips the 48-bit cyclic prefix and presents the 128-bit in-phase and 128-bit quadrature time-domain vectors to the receive FFT.
- Flags a prefix/tail mismatch and any loss of word alignment.

---
 rtl/ofdm_pkg.sv | 21 ++
 rtl/cp_strip_check.sv | 16 +
 rtl/input_module_16to304.sv | 106 ++++++++++
 tb/tb_input_module_16to304.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Constants shared across the OFDM transmit/receive chain.
// Symbol = 48-bit cyclic prefix + 256-bit body {phase, quad}.
package ofdm_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_WORDS = 19;
  localparam int CP_WORDS  = 3;
  localparam int SYM_W     = NUM_WORDS * DATA_W;
  localparam int BODY_W    = 256;
  localparam int HALF_W    = 128;
  localparam int CP_W      = CP_WORDS * DATA_W;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } rx_state_e;

endpackage

// File: rtl/cp_strip_check.sv
// Splits a cyclic-prefixed symbol into phase/quad halves and
// flags a prefix that does not match the symbol tail.
module cp_strip_check
  import ofdm_pkg::*;
(
  input  logic [SYM_W-1:0]  sym,
  output logic [HALF_W-1:0] phase,
  output logic [HALF_W-1:0] quad,
  output logic              mismatch
);

  assign phase    = sym[BODY_W-1:HALF_W];
  assign quad     = sym[HALF_W-1:0];
  assign mismatch = sym[SYM_W-1 -: CP_W] != sym[CP_W-1:0];

endmodule

// File: rtl/input_module_16to304.sv
// Receive deserializer: 16-bit words in, one 304-bit symbol out,
// with resync on sym_start and a one-deep hold on backpressure.
module input_module_16to304
  import ofdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              sym_start,
  output logic              ready_out,
  output logic [SYM_W-1:0]  symbol_out,
  output logic [HALF_W-1:0] phase_out,
  output logic [HALF_W-1:0] quad_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              cp_err,
  output logic              sync_err
);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0] acc_q, acc_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;

  logic             acc_en;
  logic             out_free;
  logic [SYM_W-1:0] shifted;

  assign ready_out = (state_q == FILL);
  assign acc_en    = valid_in && ready_out;
  assign out_free  = !valid_q || ready_in;
  assign shifted   = {acc_q[SYM_W-DATA_W-1:0], data_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sym_d   = sym_q;
    valid_d = valid_q && !ready_in;
    sync_d  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (acc_en) begin
          acc_d = shifted;
          if (sym_start) begin
            cnt_d  = CNT_W'(1);
            sync_d = (cnt_q != '0);
          end else if (cnt_q == LAST_WORD) begin
            cnt_d = '0;
            if (out_free) begin
              sym_d   = shifted;
              valid_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (ready_in) begin
          sym_d   = acc_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
    end
  end

  // cp_err follows the held symbol, so it changes only on an output load
  cp_strip_check u_cp (
    .sym      (sym_q),
    .phase    (phase_out),
    .quad     (quad_out),
    .mismatch (cp_err)
  );

  assign symbol_out = sym_q;
  assign valid_out  = valid_q;
  assign sync_err   = sync_q;

endmodule

// File: tb/tb_input_module_16to304.sv
// Directed bench for the 16-to-304 receive deserializer.
module tb_input_module_16to304;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  data_in;
  logic         valid_in;
  logic         sym_start;
  logic         ready_out;
  logic [303:0] symbol_out;
  logic [127:0] phase_out;
  logic [127:0] quad_out;
  logic         valid_out;
  logic         ready_in;
  logic         cp_err;
  logic         sync_err;

  int tests = 0;
  int fails = 0;

  logic [15:0]  w [19];
  logic [303:0] exp_a, exp_b, exp_c, exp_d;

  always #5 clk = ~clk;

  input_module_16to304 dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .sym_start  (sym_start),
    .ready_out  (ready_out),
    .symbol_out (symbol_out),
    .phase_out  (phase_out),
    .quad_out   (quad_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .cp_err     (cp_err),
    .sync_err   (sync_err)
  );

  task automatic chk(input string tag, input logic [303:0] obs,
                     input logic [303:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] d, input logic ss);
    data_in   = d;
    valid_in  = 1'b1;
    sym_start = ss;
    step();
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    sym_start = 1'b0;
    step();
  endtask

  task automatic set_w(input logic [15:0] p0, input logic [15:0] p1,
                       input logic [15:0] p2, input logic [15:0] base);
    for (int k = 0; k < 19; k++) w[k] = base + 16'(k);
    w[0] = p0; w[1] = p1; w[2] = p2;
    w[16] = p0; w[17] = p1; w[18] = p2;
  endtask

  function automatic logic [303:0] pack_w();
    logic [303:0] s;
    for (int k = 0; k < 19; k++) s[303-16*k -: 16] = w[k];
    return s;
  endfunction

  task automatic send_w();
    for (int k = 0; k < 19; k++) put(w[k], k == 0);
  endtask

  initial begin
    int  nval;
    int  pos0, pos1;
    int  not_ready;
    int  sync_seen;
    logic [303:0] cap1;

    reset = 1'b0; data_in = '0; valid_in = 1'b0;
    sym_start = 1'b0; ready_in = 1'b1;
    #12;
    chk("rst_valid", 304'(valid_out), 304'(0));
    chk("rst_ready", 304'(ready_out), 304'(1));
    chk("rst_sym", symbol_out, '0);
    chk("rst_cperr", 304'(cp_err), 304'(0));
    chk("rst_syncerr", 304'(sync_err), 304'(0));
    @(negedge clk); reset = 1'b1;
    step();

    // single symbol
    set_w(16'hA001, 16'hA002, 16'hA003, 16'h1000);
    exp_a = pack_w();
    for (int k = 0; k < 18; k++) put(w[k], k == 0);
    chk("s1_not_yet", 304'(valid_out), 304'(0));
    put(w[18], 1'b0);
    chk("s1_valid", 304'(valid_out), 304'(1));
    chk("s1_phase", 304'(phase_out),
        304'(128'h1003100410051006100710081009100A));
    chk("s1_quad", 304'(quad_out),
        304'(128'h100B100C100D100E100FA001A002A003));
    chk("s1_sym", symbol_out, exp_a);
    chk("s1_cperr", 304'(cp_err), 304'(0));
    idle();
    chk("s1_consumed", 304'(valid_out), 304'(0));

    // back-to-back, 38 words with valid_in held high
    nval = 0; pos0 = -1; pos1 = -1; not_ready = 0;
    set_w(16'hC001, 16'hC002, 16'hC003, 16'h2000);
    exp_b = pack_w();
    for (int k = 0; k < 19; k++) begin
      if (!ready_out) not_ready++;
      put(w[k], k == 0);
      if (valid_out) begin nval++; pos0 = k; cap1 = symbol_out; end
    end
    chk("b2b_sym1", cap1, exp_b);
    set_w(16'hD001, 16'hD002, 16'hD003, 16'h3000);
    exp_c = pack_w();
    for (int k = 0; k < 19; k++) begin
      if (!ready_out) not_ready++;
      put(w[k], k == 0);
      if (valid_out) begin nval++; pos1 = k + 19; end
    end
    chk("b2b_nvalid", 304'(nval), 304'(2));
    chk("b2b_gap", 304'(pos1 - pos0), 304'(19));
    chk("b2b_sym2", symbol_out, exp_c);
    chk("b2b_ready", 304'(not_ready), 304'(0));
    idle();

    // backpressure: second completion parks in HOLD
    ready_in = 1'b0;
    set_w(16'hE001, 16'hE002, 16'hE003, 16'h4000);
    exp_d = pack_w();
    send_w();
    chk("bp_sym1", symbol_out, exp_d);
    set_w(16'hF001, 16'hF002, 16'hF003, 16'h5000);
    send_w();
    chk("bp_hold_ready", 304'(ready_out), 304'(0));
    chk("bp_hold_valid", 304'(valid_out), 304'(1));
    chk("bp_stable", symbol_out, exp_d);
    put(16'h7777, 1'b1);
    idle();
    chk("bp_still_hold", 304'(ready_out), 304'(0));
    chk("bp_still_sym1", symbol_out, exp_d);
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    chk("bp_sym2", symbol_out, pack_w());
    chk("bp_sym2_valid", 304'(valid_out), 304'(1));
    chk("bp_ready_back", 304'(ready_out), 304'(1));
    ready_in = 1'b1;
    step();
    chk("bp_drained", 304'(valid_out), 304'(0));

    // resync on the 7th word
    for (int k = 0; k < 6; k++) put(16'h0BAD + 16'(k), k == 0);
    chk("rs_no_pulse", 304'(sync_err), 304'(0));
    set_w(16'h9001, 16'h9002, 16'h9003, 16'h6000);
    put(w[0], 1'b1);
    chk("rs_pulse", 304'(sync_err), 304'(1));
    put(w[1], 1'b0);
    chk("rs_pulse_end", 304'(sync_err), 304'(0));
    for (int k = 2; k < 19; k++) put(w[k], 1'b0);
    chk("rs_valid", 304'(valid_out), 304'(1));
    chk("rs_sym", symbol_out, pack_w());
    idle();

    // prefix error, held by backpressure into the reset test
    ready_in = 1'b0;
    set_w(16'hA001, 16'hA002, 16'hA003, 16'h1000);
    w[1] = 16'hBEEF;
    send_w();
    chk("cp_valid", 304'(valid_out), 304'(1));
    chk("cp_err", 304'(cp_err), 304'(1));
    chk("cp_sym", symbol_out, pack_w());

    // async reset after 10 words
    for (int k = 0; k < 10; k++) put(16'h3300 + 16'(k), k == 0);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 304'(valid_out), 304'(0));
    chk("ar_ready", 304'(ready_out), 304'(1));
    chk("ar_sym", symbol_out, '0);
    chk("ar_cperr", 304'(cp_err), 304'(0));
    @(negedge clk); reset = 1'b1;
    ready_in = 1'b1;
    valid_in = 1'b0;
    step();
    set_w(16'h8001, 16'h8002, 16'h8003, 16'h7000);
    sync_seen = 0;
    for (int k = 0; k < 19; k++) begin
      put(w[k], k == 0);
      if (sync_err) sync_seen++;
    end
    chk("ar_nosync", 304'(sync_seen), 304'(0));
    chk("ar_valid2", 304'(valid_out), 304'(1));
    chk("ar_sym2", symbol_out, pack_w());
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
